grey_sync_rx: RTL and testbench

Receive-side stage for the binary-to-Gray converter. It takes a Gray-coded count launched from another clock domain and passes it through a multi-flop synchronizer. It then decodes it back to natural binary and reports each change as a single-cycle valid pulse, together with the modulo step size. It also checks every step for Gray-code legality, so that pointer and counter crossings between domains can be monitored.

---
 rtl/grey_pkg.sv | 32 +++
 rtl/grey_sync_chain.sv | 30 +++
 rtl/grey_sync_rx.sv | 96 +++++++++
 tb/tb_grey_sync_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/grey_pkg.sv
// Shared Gray-code helpers and FSM state type.
// Used by grey_sync_rx and the transmit-side converter.
package grey_pkg;

  typedef enum logic [0:0] {
    INIT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  localparam int GMAXW = 32;

  // Loop covers the widest supported code; narrower codes
  // are zero-extended, so the upper bits decode to zero.
  function automatic logic [GMAXW-1:0] grey2nat(
    input logic [GMAXW-1:0] g
  );
    logic [GMAXW-1:0] b;
    b = '0;
    b[GMAXW-1] = g[GMAXW-1];
    for (int i = GMAXW-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [GMAXW-1:0] nat2grey(
    input logic [GMAXW-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/grey_sync_chain.sv
// Reset-to-zero multi-flop synchronizer for a Gray bus.
// Ports: clk, rst_n, grey_in (async domain), grey_s (synced).
module grey_sync_chain #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] grey_in,
  output logic [WIDTH-1:0] grey_s
);

  logic [WIDTH-1:0] q [SYNC_STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        q[i] <= '0;
      end
    end else begin
      q[0] <= grey_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        q[i] <= q[i-1];
      end
    end
  end

  assign grey_s = q[SYNC_STAGES-1];

endmodule

// File: rtl/grey_sync_rx.sv
// Gray receive stage: sync, decode, change pulse, delta, checker.
// Ports: clk, rst_n, grey_in, en, clr -> nature_out, nature_vld,
// delta, err, err_sticky. Checker built with GREY_SYNC_RX_CHECK_EN.
module grey_sync_rx #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] grey_in,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] nature_out,
  output logic             nature_vld,
  output logic [WIDTH-1:0] delta,
  output logic             err,
  output logic             err_sticky
);

  import grey_pkg::*;

  logic [WIDTH-1:0] grey_s;
  logic [WIDTH-1:0] grey_p;
  logic [WIDTH-1:0] nat;
  state_t           state;

  grey_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .grey_in(grey_in),
    .grey_s (grey_s)
  );

  assign nat = WIDTH'(grey2nat(GMAXW'(grey_s)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= INIT;
      grey_p     <= '0;
      nature_out <= '0;
      nature_vld <= 1'b0;
      delta      <= '0;
    end else begin
      nature_vld <= 1'b0;
      unique case (1'b1)
        (state == INIT): begin
          if (en) begin
            grey_p     <= grey_s;
            nature_out <= nat;
            delta      <= '0;
            state      <= TRACK;
          end
        end
        (state == TRACK): begin
          if (!en) begin
            state <= INIT;
          end else if (grey_s != grey_p) begin
            grey_p     <= grey_s;
            nature_out <= nat;
            nature_vld <= 1'b1;
            // modulo subtraction: wrap reads as +1
            delta      <= nat - nature_out;
          end
        end
      endcase
    end
  end

`ifdef GREY_SYNC_RX_CHECK_EN
  logic illegal;

  assign illegal = (state == TRACK) && en &&
                   ($countones(grey_s ^ grey_p) > 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err        <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      err        <= illegal;
      // a new error beats a simultaneous clear
      err_sticky <= illegal | (err_sticky & ~clr);
    end
  end
`else
  logic unused_clr;

  assign unused_clr = clr;
  assign err        = 1'b0;
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_grey_sync_rx.sv
// Self-checking bench for grey_sync_rx (WIDTH=5, SYNC_STAGES=2).
// Directed plan steps followed by randomized Gray traffic.
module tb_grey_sync_rx;

  localparam int W = 5;
  localparam int S = 2;
`ifdef GREY_SYNC_RX_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] grey_in = '0;
  logic         en = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] nature_out;
  logic         nature_vld;
  logic [W-1:0] delta;
  logic         err;
  logic         err_sticky;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_track, m_gp, m_nat, m_vld, m_delta, m_err, m_sticky;
  int hist[$];

  grey_sync_rx #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .grey_in   (grey_in),
    .en        (en),
    .clr       (clr),
    .nature_out(nature_out),
    .nature_vld(nature_vld),
    .delta     (delta),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Gray -> binary as XOR of all right shifts
  function automatic int dec(int g);
    int b = 0;
    for (int k = 0; k < W; k++) b = b ^ (g >> k);
    return b & ((1 << W) - 1);
  endfunction

  function automatic int pop(int v);
    int c = 0;
    for (int k = 0; k < W; k++) c += (v >> k) & 1;
    return c;
  endfunction

  task automatic model_reset();
    m_track = 0; m_gp = 0; m_nat = 0; m_vld = 0;
    m_delta = 0; m_err = 0; m_sticky = 0;
    hist = {};
    for (int i = 0; i < S; i++) hist.push_back(0);
  endtask

  // value in use at an edge was sampled S edges earlier
  task automatic model_edge();
    int gs;
    int ill;
    gs = hist.pop_front();
    hist.push_back(int'(grey_in));
    m_vld = 0;
    m_err = 0;
    ill = 0;
    if (m_track == 0) begin
      if (en) begin
        m_gp = gs; m_nat = dec(gs); m_delta = 0; m_track = 1;
      end
    end else if (!en) begin
      m_track = 0;
    end else if (gs != m_gp) begin
      ill = (pop(gs ^ m_gp) > 1);
      m_delta = (dec(gs) - m_nat) & ((1 << W) - 1);
      m_nat = dec(gs);
      m_gp = gs;
      m_vld = 1;
    end
    if (CHK) begin
      m_err = ill;
      m_sticky = (ill != 0 || (m_sticky != 0 && !clr)) ? 1 : 0;
    end
  endtask

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, ".nat"}, int'(nature_out), m_nat);
    chk({tag, ".vld"}, int'(nature_vld), m_vld);
    chk({tag, ".delta"}, int'(delta), m_delta);
    chk({tag, ".err"}, int'(err), m_err);
    chk({tag, ".sticky"}, int'(err_sticky), m_sticky);
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    model_edge();
    #1;
    chk_all(tag);
    @(negedge clk);
  endtask

  task automatic ticks(int n, string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  initial begin
    int g;
    int b;
    model_reset();

    // reset with a nonzero code waiting at the input
    grey_in = 5'b10101;
    en = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all("reset");
    chk("reset.nat0", int'(nature_out), 0);
    en = 1'b0;
    rst_n = 1'b1;
    ticks(2, "fill");
    en = 1'b1;
    tick("first");
    chk("first.nat25", int'(nature_out), 25);
    chk("first.novld", int'(nature_vld), 0);

    // increment 0 -> 1
    grey_in = 5'b00000;
    ticks(3, "base0");
    grey_in = 5'b00001;
    ticks(3, "inc");
    chk("inc.nat1", int'(nature_out), 1);
    chk("inc.vld", int'(nature_vld), 1);
    chk("inc.delta1", int'(delta), 1);
    tick("inc.after");
    chk("inc.vld_drop", int'(nature_vld), 0);

    // wrap 31 -> 0
    grey_in = 5'b10000;
    ticks(3, "base31");
    grey_in = 5'b00000;
    ticks(3, "wrap");
    chk("wrap.nat0", int'(nature_out), 0);
    chk("wrap.delta1", int'(delta), 1);
    chk("wrap.err0", int'(err), 0);

    // illegal jump 0 -> 2
    grey_in = 5'b00011;
    ticks(3, "jump");
    chk("jump.nat2", int'(nature_out), 2);
    chk("jump.delta2", int'(delta), 2);
    chk("jump.err", int'(err), int'(CHK));
    chk("jump.sticky", int'(err_sticky), int'(CHK));
    clr = 1'b1;
    tick("clr");
    chk("clr.sticky0", int'(err_sticky), 0);
    clr = 1'b0;
    grey_in = 5'b00010;
    ticks(3, "back3");
    grey_in = 5'b00000;
    ticks(3, "back0");
    grey_in = 5'b00011;
    ticks(2, "jump2");
    clr = 1'b1;
    tick("jump2.clr");
    chk("setwins.sticky", int'(err_sticky), int'(CHK));
    clr = 1'b0;

    // enable gap re-baselines silently
    en = 1'b0;
    grey_in = 5'b00100;
    ticks(3, "gap");
    en = 1'b1;
    tick("rebase");
    chk("rebase.nat7", int'(nature_out), 7);
    chk("rebase.novld", int'(nature_vld), 0);
    grey_in = 5'b01100;
    ticks(3, "gap.step");
    chk("gap.vld", int'(nature_vld), 1);
    chk("gap.delta1", int'(delta), 1);

    // async reset while vld is high
    grey_in = 5'b01101;
    ticks(3, "pre_rst");
    chk("pre_rst.vld", int'(nature_vld), 1);
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick("post_rst");
    chk("post_rst.novld", int'(nature_vld), 0);

    // randomized traffic: mostly single steps, some jumps
    b = 0;
    for (int i = 0; i < 400; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) b = (b + 1) & 31;
      else if (r < 70) b = (b - 1) & 31;
      else if (r < 78) b = int'($urandom_range(0, 31));
      g = b ^ (b >> 1);
      grey_in = W'(g);
      en = ($urandom_range(0, 99) < 90);
      clr = ($urandom_range(0, 99) < 10);
      if ($urandom_range(0, 9) < 4) tick("rand");
      else ticks(int'($urandom_range(1, 3)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
